// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if
// Signals between the keypad scanner, the Pmod KYPD pins and the display or
// event consumers.
//   row      : keypad row inputs, active-low, pulled up, asynchronous
//   col      : column drives, one-cold active-low
//   DispVal  : hex code of the last accepted key (to the display controller)
//   keyValid : one-cycle pulse whenever DispVal is (re)loaded
//   keyHeld  : high while a debounced key is down
// Modports: master = scanner side, slave = keypad model / consumer side.
// ---------------------------------------------------------------------------
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] DispVal;
    logic       keyValid;
    logic       keyHeld;

    modport master (
        input  row,
        output col,
        output DispVal,
        output keyValid,
        output keyHeld
    );

    modport slave (
        output row,
        input  col,
        input  DispVal,
        input  keyValid,
        input  keyHeld
    );
endinterface

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 matrix keypad one column per slot, classifies each four-slot
// frame as NONE / KEY(code) / MULTI, debounces the result over DEBOUNCE_CNT
// identical frames and presents the accepted key as a hex code.
//
// Parameters:
//   SCAN_DIV      : clock cycles per column slot (>= 4)
//   DEBOUNCE_CNT  : identical frames needed to accept a press/release (1..15)
//   REPEAT_FRAMES : frames between auto-repeat pulses (repeat build only)
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   kp    : keypad_scanner_if.master (row in; col, DispVal, keyValid,
//           keyHeld out)
// Build option:
//   KYPD_REPEAT_EN : when defined, keyValid re-pulses every REPEAT_FRAMES
//                    complete frames while a key stays pressed.
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV      = 100000,
    parameter int DEBOUNCE_CNT  = 4,
    parameter int REPEAT_FRAMES = 128
) (
    input logic              clk,
    input logic              rst_n,
    keypad_scanner_if.master kp
);
    localparam int               SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_MAX   = 4'(DEBOUNCE_CNT);
    // Key code per {column, row}, 4 bits each, entry 0 = col0/row0.
    localparam logic [63:0]      KEYMAP    = 64'hDCBA_E963_F852_0741;

    // Parameter sanity checks at elaboration.
    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be >= 4");
    end
    if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_CNT must be 1..15");
    end
    if (REPEAT_FRAMES < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_FRAMES must be >= 1");
    end

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    logic [3:0]        row_meta_q, row_sync_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        hits_q, hits_d;        // lows seen so far: 0, 1, 2 = many
    logic [3:0]        code_q, code_d;
    logic              prev_key_q, prev_key_d;
    logic [3:0]        prev_code_q, prev_code_d;
    logic [3:0]        stab_q, stab_d;
    state_t            state_q, state_d;
    logic [3:0]        disp_q, disp_d;
    logic              valid_q, valid_d;

    logic              sample_en, frame_end;
    logic [3:0]        row_low;
    logic [3:0]        row_code [4];
    logic [1:0]        slot_hits, tot_hits;
    logic [3:0]        slot_code, tot_code;
    logic              res_key, same_res, deb_hit, key_match;
    logic              accept, stay_pressed, rep_fire;

    // Rows are sampled on the last cycle of a slot, before the column moves.
    assign sample_en = (slot_q == SLOT_LAST);
    assign frame_end = sample_en && (col_idx_q == 2'd3);

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign row_low[gi]  = ~row_sync_q[gi];
        assign row_code[gi] = KEYMAP[{col_idx_q, 2'(gi), 2'b00} +: 4];
    end

    // Lows in the current slot, saturating at "many".
    always_comb begin
        slot_hits = 2'd0;
        slot_code = 4'h0;
        for (int j = 0; j < 4; j++) begin
            if (row_low[j]) begin
                slot_hits = (slot_hits == 2'd0) ? 2'd1 : 2'd2;
                slot_code = row_code[j];
            end
        end
    end

    // Whole-frame tally including the slot being sampled right now.
    always_comb begin
        if (hits_q == 2'd0) begin
            tot_hits = slot_hits;
        end else if (slot_hits == 2'd0) begin
            tot_hits = hits_q;
        end else begin
            tot_hits = 2'd2;
        end
        tot_code = (slot_hits != 2'd0) ? slot_code : code_q;
    end

    // MULTI collapses to NONE for everything downstream.
    assign res_key   = (tot_hits == 2'd1);
    assign same_res  = (res_key == prev_key_q) && (!res_key || (tot_code == prev_code_q));
    assign key_match = res_key && (tot_code == disp_q);

    always_comb begin
        slot_d      = sample_en ? '0 : slot_q + SLOT_W'(1);
        col_idx_d   = sample_en ? col_idx_q + 2'd1 : col_idx_q;
        hits_d      = hits_q;
        code_d      = code_q;
        prev_key_d  = prev_key_q;
        prev_code_d = prev_code_q;
        stab_d      = stab_q;
        if (sample_en) begin
            hits_d = frame_end ? 2'd0 : tot_hits;
            code_d = frame_end ? 4'h0 : tot_code;
        end
        if (frame_end) begin
            if (same_res) begin
                stab_d = (stab_q >= DEB_MAX) ? DEB_MAX : stab_q + 4'd1;
            end else begin
                stab_d      = 4'd1;
                prev_key_d  = res_key;
                prev_code_d = res_key ? tot_code : 4'h0;
            end
        end
    end

    assign deb_hit = (stab_d >= DEB_MAX);

    // Debounce FSM; only frame ends can move it.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        stay_pressed = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                RELEASED: begin
                    if (res_key) begin
                        if (deb_hit) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_d = PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    // A different key reloads the count, so deb_hit here
                    // implies the same key for DEBOUNCE_CNT frames.
                    if (!res_key) begin
                        state_d = RELEASED;
                    end else if (deb_hit) begin
                        state_d = PRESSED;
                        accept  = 1'b1;
                    end
                end
                PRESSED: begin
                    if (key_match) begin
                        stay_pressed = 1'b1;
                    end else if (!res_key && deb_hit) begin
                        state_d = RELEASED;
                    end else begin
                        state_d = RELEASE_PEND;
                    end
                end
                RELEASE_PEND: begin
                    // Another key held here is ignored until a full release.
                    if (key_match) begin
                        state_d = PRESSED;
                    end else if (!res_key && deb_hit) begin
                        state_d = RELEASED;
                    end
                end
                default: state_d = RELEASED;
            endcase
        end
        disp_d  = accept ? tot_code : disp_q;
        valid_d = accept | rep_fire;
    end

`ifdef KYPD_REPEAT_EN
    localparam int             REP_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);

    logic [REP_W-1:0] rep_q, rep_d;

    // Counts whole frames spent in PRESSED; a return from RELEASE_PEND keeps
    // the frozen count, only a fresh acceptance restarts it.
    assign rep_fire = stay_pressed && (rep_q == REP_LAST);

    always_comb begin
        rep_d = rep_q;
        if (accept || rep_fire) begin
            rep_d = '0;
        end else if (stay_pressed) begin
            rep_d = rep_q + REP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            slot_q      <= '0;
            col_idx_q   <= 2'd0;
            hits_q      <= 2'd0;
            code_q      <= 4'h0;
            prev_key_q  <= 1'b0;
            prev_code_q <= 4'h0;
            stab_q      <= 4'd0;
            state_q     <= RELEASED;
            disp_q      <= 4'h0;
            valid_q     <= 1'b0;
        end else begin
            row_meta_q  <= kp.row;
            row_sync_q  <= row_meta_q;
            slot_q      <= slot_d;
            col_idx_q   <= col_idx_d;
            hits_q      <= hits_d;
            code_q      <= code_d;
            prev_key_q  <= prev_key_d;
            prev_code_q <= prev_code_d;
            stab_q      <= stab_d;
            state_q     <= state_d;
            disp_q      <= disp_d;
            valid_q     <= valid_d;
        end
    end

    assign kp.col      = ~(4'b0001 << col_idx_q);
    assign kp.DispVal  = disp_q;
    assign kp.keyValid = valid_q;
    assign kp.keyHeld  = (state_q == PRESSED) || (state_q == RELEASE_PEND);

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Keypad matrix model plus a scoreboard of expected keyValid pulses
// (code and cycle). Frame = 16 cycles with SCAN_DIV=4, DEBOUNCE_CNT=2.
// Key changes are applied on frame boundaries relative to reset release.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;
    localparam int SCAN_DIV      = 4;
    localparam int DEBOUNCE_CNT  = 2;
    localparam int REPEAT_FRAMES = 3;
    localparam int FRAME         = 4 * SCAN_DIV;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = 16'h0;     // bit c*4+r = key at column c, row r
    logic [3:0]  row_drv;
    int          cyc = 0;
    int          t0 = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q [$];

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_CNT  (DEBOUNCE_CNT),
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row_drv = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!kp.col[c] && keys[c*4+r]) row_drv[r] = 1'b0;
            end
        end
    end
    assign kp.row = row_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] key_bit(input int c, input int r);
        logic [15:0] one;
        one = 16'h1;
        return one << (c * 4 + r);
    endfunction

    task automatic push_exp(input logic [3:0] code, input int frame_no);
        exp_t e;
        e.code = code;
        e.due  = 32'(t0 + frame_no * FRAME);
        exp_q.push_back(e);
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(kp.col), 32'h0000_000E);
        check("rst_disp", 32'(kp.DispVal), 32'h0);
        check("rst_valid", 32'(kp.keyValid), 32'h0);
        check("rst_held", 32'(kp.keyHeld), 32'h0);
        rst_n = 1'b1;
        t0 = cyc;
    endtask

    // Scoreboard consumer: every pulse must match the next expected entry.
    always @(negedge clk) begin
        if (kp.keyValid) begin
            if (exp_q.size() == 0) begin
                check("unexp_pulse", 32'(kp.DispVal), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_code", 32'(kp.DispVal), 32'(e.code));
                check("pulse_cycle", 32'(cyc), e.due);
                $display("pulse code=%0h cycle=%0d", kp.DispVal, cyc - t0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] col_exp [5];
        col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // Reset and column stepping.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("col_step", 32'(kp.col), 32'(col_exp[i]));
            if (i < 4) repeat (SCAN_DIV) @(negedge clk);
        end
        $display("scenario reset done");

        // Clean press of key 5 (col1,row1), then release.
        keys = 16'h0;
        do_reset();
        keys = key_bit(1, 1);
        push_exp(4'h5, 2);
        wait_frames(3);
        check("press5_disp", 32'(kp.DispVal), 32'h5);
        check("press5_held", 32'(kp.keyHeld), 32'h1);
        keys = 16'h0;
        wait_frames(1);
        check("rel5_pend_held", 32'(kp.keyHeld), 32'h1);
        wait_frames(1);
        check("rel5_held", 32'(kp.keyHeld), 32'h0);
        check("rel5_disp", 32'(kp.DispVal), 32'h5);
        $display("scenario clean press done");

        // Bounce on key D (col3,row3): toggle for 4 frames, then hold.
        keys = 16'h0;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            keys = (f % 2 == 0) ? key_bit(3, 3) : 16'h0;
            wait_frames(1);
        end
        check("bounce_quiet", 32'(kp.keyHeld), 32'h0);
        keys = key_bit(3, 3);
        push_exp(4'hD, 6);
        wait_frames(1);
        check("bounce_mid_disp", 32'(kp.DispVal), 32'h0);
        wait_frames(2);
        check("bounce_disp", 32'(kp.DispVal), 32'hD);
        $display("scenario bounce done");

        // Ghost: keys 1 and 6 together never report.
        keys = 16'h0;
        do_reset();
        keys = key_bit(0, 0) | key_bit(2, 1);
        wait_frames(3);
        check("multi_disp", 32'(kp.DispVal), 32'h0);
        check("multi_held", 32'(kp.keyHeld), 32'h0);
        $display("scenario multi done");

        // Hold A, slide straight to B, then release.
        keys = 16'h0;
        do_reset();
        keys = key_bit(3, 0);
        push_exp(4'hA, 2);
        wait_frames(3);
        keys = key_bit(3, 1);
        wait_frames(3);
        check("change_disp", 32'(kp.DispVal), 32'hA);
        check("change_held", 32'(kp.keyHeld), 32'h1);
        keys = 16'h0;
        wait_frames(2);
        check("change_rel_held", 32'(kp.keyHeld), 32'h0);
        check("change_rel_disp", 32'(kp.DispVal), 32'hA);
        $display("scenario change done");

        // Reset during PRESS_PEND for key 9 (col2,row2), key kept down.
        keys = 16'h0;
        do_reset();
        keys = key_bit(2, 2);
        wait_frames(1);
        repeat (SCAN_DIV) @(negedge clk);
        do_reset();
        push_exp(4'h9, 2);
        wait_frames(1);
        check("midrst_pend_held", 32'(kp.keyHeld), 32'h0);
        wait_frames(2);
        check("midrst_disp", 32'(kp.DispVal), 32'h9);
        check("midrst_held", 32'(kp.keyHeld), 32'h1);
        $display("scenario mid-press reset done");

`ifdef KYPD_REPEAT_EN
        // Auto-repeat: hold 7 (col0,row2) for 10 frames.
        keys = 16'h0;
        do_reset();
        keys = key_bit(0, 2);
        push_exp(4'h7, 2);
        push_exp(4'h7, 5);
        push_exp(4'h7, 8);
        wait_frames(10);
        check("repeat_disp", 32'(kp.DispVal), 32'h7);
        keys = 16'h0;
        wait_frames(2);
        $display("scenario repeat done");
`endif

        keys = 16'h0;
        repeat (4) @(negedge clk);
        check("pending_pulses", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 Pmod KYPD matrix keypad, debounces key presses and presents the pressed key as a 4-bit hex code to the seven-segment display stage. It sits directly upstream of the display controller: its `DispVal` output feeds that block's `DispVal` input unchanged. Its `keyValid` and `keyHeld` outputs serve any consumer that needs press events.

## Interface
- `SCAN_DIV`, 100000: clock cycles per column slot (1 ms at 100 MHz); legal minimum 4.
- `DEBOUNCE_CNT`, 4: consecutive identical frame results needed to accept a press or a release; legal range 1–15.
- `REPEAT_FRAMES`, 128: frames between auto-repeat pulses; used only with `KYPD_REPEAT_EN`.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `row`  in  4  keypad row inputs, active-low, externally pulled up, asynchronous.
- `col`  out  4  column drives, one-cold active-low.
- `DispVal`  out  4  hex code of the last accepted key.
- `keyValid`  out  1  one-cycle pulse when `DispVal` is (re)loaded.
- `keyHeld`  out  1  high while a debounced key is down.

## Operation
- **Row synchronizer:** `row` passes through a 2-flop synchronizer before any use.
- **Column scan:**
  - Slot counter runs 0..`SCAN_DIV`-1.
  - Column index 0..3 drives `col[i]` low for slot i and advances at slot-counter wrap. Index 3 wraps to 0.
  - Four slots make one frame.
- **Row sampling:** synchronized rows are sampled on the last cycle of each slot (counter == `SCAN_DIV`-1), before the column changes.
- **Frame result:** computed at the end of slot 3.
  - NONE: no low row in any slot.
  - KEY(code): exactly one low row across the whole frame.
  - MULTI: more than one low row. MULTI is treated as NONE for debounce and never changes `DispVal`.
- **Key map** (column i, row j active-low):
  - col0: rows 0..3 → 1, 4, 7, 0
  - col1: rows 0..3 → 2, 5, 8, F
  - col2: rows 0..3 → 3, 6, 9, E
  - col3: rows 0..3 → A, B, C, D
- **Stability counter:**
  - Increments, saturating at `DEBOUNCE_CNT`, when the frame result equals the previous result.
  - Otherwise it loads 1 and the previous result becomes the new one.
- **FSM states:** RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - RELEASED → PRESS_PEND on a KEY result.
  - PRESS_PEND → PRESSED when the count reaches `DEBOUNCE_CNT` with the same KEY. This loads `DispVal` and pulses `keyValid`.
  - PRESS_PEND → RELEASED on NONE.
  - PRESS_PEND restarts on a different KEY.
  - PRESSED → RELEASE_PEND on NONE or a different KEY. A different key is never accepted until a release is debounced.
  - RELEASE_PEND → RELEASED when NONE reaches `DEBOUNCE_CNT`; `keyHeld` drops.
  - RELEASE_PEND → PRESSED if the original KEY returns.
- **Outputs:** `keyHeld` = state is PRESSED or RELEASE_PEND. `DispVal` holds its value through release.

## Timing
- **Reset values:** `col`=4'b1110, `DispVal`=4'h0, `keyValid`=0, `keyHeld`=0, state RELEASED, all counters 0.
- **Reset mid-scan or mid-press:** all of the above are restored on the next edge; no pending event survives.
- **Press latency:** the key is accepted at the end of the `DEBOUNCE_CNT`-th consecutive identical frame. `DispVal`, `keyValid` and `keyHeld` all update on the clock edge following that frame's final sample.
- **`keyValid` width:** exactly 1 cycle.
- **Synchronizer margin:** 2-cycle synchronizer latency is below `SCAN_DIV`, so each sample reflects the currently driven column.

## Configuration
- **`KYPD_REPEAT_EN` defined:** while in PRESSED, `keyValid` re-pulses every `REPEAT_FRAMES` complete frames with `DispVal` unchanged. The repeat counter clears on entry to PRESSED and on reset; RELEASE_PEND freezes it.
- **`KYPD_REPEAT_EN` undefined:** one `keyValid` pulse per debounced press; no repeat logic is synthesized.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_CNT`=2 (frame = 16 cycles).
- **Reset:** hold `rst_n`=0 for 3 cycles → `col`=1110, `DispVal`=0, `keyValid`=0, `keyHeld`=0. After release, `col` steps 1110→1101→1011→0111→1110 every 4 cycles.
- **Clean press:** model key 5 (`row[1]` low while `col[1]` low) for 3 frames → one `keyValid` pulse at end of frame 2, `DispVal`=4'h5, `keyHeld`=1. Release → `keyHeld`=0 after 2 NONE frames, `DispVal` stays 5.
- **Bounce:** key D (col3/row3) toggles every frame for 4 frames, then held → no pulse during toggling; `DispVal`=4'hD exactly 2 stable frames after the toggling stops.
- **Ghost and change:** press 1 and 6 together (MULTI) → no pulse, `DispVal` unchanged. Hold A, then switch directly to B without a gap → only A is reported until a NONE release is debounced.
- **Mid-press reset:** assert `rst_n`=0 during PRESS_PEND for key 9 → no pulse, outputs at reset values. Key still held → reported 2 frames after reset release.
- **`KYPD_REPEAT_EN` with `REPEAT_FRAMES`=3:** hold 7 for 10 frames → pulses at frames 2, 5, 8; `DispVal`=7 throughout.
